reg_write_arbiter: RTL and testbench

- Shares the single write port of the register bank (`Register` instances with `we`) between 4 requesters: CPU writeback, load unit, I/O unit and debug port.
- A round-robin grant is computed each cycle from valid/ready-style requests.
- The winning address and data are registered onto the bank write bus.
- Optional lock bursts give one requester consecutive writes, capped by a maximum burst length.

---
 rtl/reg_write_arbiter.sv | 157 +++++++++++++++
 tb/tb_reg_write_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port between 4 requesters,
// with capped lock bursts. Define REG_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest).
module reg_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [3:0]            lock,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*WIDTH-1:0]    req_data,
    output logic [3:0]            gnt,
    output logic                  wr_we,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  busy
);

    localparam logic [4:0] MAX_B   = 5'(MAX_BURST);
    localparam bit         LOCK_EN = (MAX_BURST > 1);

    typedef enum logic {
        OPEN,
        LOCKED
    } state_t;

    state_t              state_reg, state_next;
    logic [1:0]          holder_reg, holder_next;
    logic [3:0]          burst_cnt_reg, burst_cnt_next;
    logic                wr_we_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [WIDTH-1:0]    wr_data_reg;

    logic [ADDR_W-1:0]   addr_arr [4];
    logic [WIDTH-1:0]    data_arr [4];
    logic [1:0]          scan_base;
    logic [3:0]          rr_gnt;
    logic                rr_found;
    logic                lock_hold;
    logic [1:0]          win_idx;
    logic                transfer;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef REG_ARB_FIXED_PRIO_EN
    assign scan_base = 2'd0;
`else
    logic [1:0] ptr_reg, ptr_next;

    // The requester just served is scanned last on the next arbitration.
    assign ptr_next  = transfer ? (win_idx + 2'd1) : ptr_reg;
    assign scan_base = ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= 2'd0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`endif

    always_comb begin
        rr_gnt   = '0;
        rr_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!rr_found && req[scan_base + 2'(k)]) begin
                rr_gnt[scan_base + 2'(k)] = 1'b1;
                rr_found                  = 1'b1;
            end
        end
    end

    assign lock_hold = (state_reg == LOCKED) && req[holder_reg] &&
                       ({1'b0, burst_cnt_reg} < MAX_B);

    always_comb begin
        gnt = '0;
        if (!rst) begin
            gnt = lock_hold ? (4'b0001 << holder_reg) : rr_gnt;
        end
    end

    always_comb begin
        win_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (gnt[k]) begin
                win_idx = 2'(k);
            end
        end
    end

    assign transfer = |gnt;

    always_comb begin
        state_next     = state_reg;
        holder_next    = holder_reg;
        burst_cnt_next = burst_cnt_reg;
        if (transfer) begin
            if (state_reg == LOCKED && win_idx == holder_reg) begin
                if (lock[win_idx] && ({1'b0, burst_cnt_reg} + 5'd1 < MAX_B)) begin
                    burst_cnt_next = burst_cnt_reg + 4'd1;
                end else begin
                    state_next     = OPEN;
                    holder_next    = 2'd0;
                    burst_cnt_next = 4'd0;
                end
            end else if (lock[win_idx] && LOCK_EN) begin
                // A fresh lock (also after a holder dropped out) starts a new burst.
                state_next     = LOCKED;
                holder_next    = win_idx;
                burst_cnt_next = 4'd1;
            end else begin
                state_next     = OPEN;
                holder_next    = 2'd0;
                burst_cnt_next = 4'd0;
            end
        end else if (state_reg == LOCKED && !req[holder_reg]) begin
            state_next     = OPEN;
            holder_next    = 2'd0;
            burst_cnt_next = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= OPEN;
            holder_reg    <= 2'd0;
            burst_cnt_reg <= 4'd0;
            wr_we_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            holder_reg    <= holder_next;
            burst_cnt_reg <= burst_cnt_next;
            wr_we_reg     <= transfer;
            if (transfer) begin
                wr_addr_reg <= addr_arr[win_idx];
                wr_data_reg <= data_arr[win_idx];
            end
        end
    end

    assign wr_we   = wr_we_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign busy    = (state_reg == LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed vector table plus randomized
// traffic checked against a rule-level model.
module tb_reg_write_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, lock, gnt;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic        wr_we, busy;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;

    int tests = 0;
    int fails = 0;

    // model state
    int          m_ptr, m_holder, m_cnt;
    logic        m_we;
    logic [2:0]  m_addr;
    logic [7:0]  m_data;

    typedef struct {
        string       name;
        logic        r;
        logic [3:0]  rq;
        logic [3:0]  lk;
        logic [3:0]  g;
        logic        we;
        logic [2:0]  a;
        logic [7:0]  d;
        logic        b;
    } vec_t;

    vec_t tab[$];

    localparam logic [11:0] TA = {3'd4, 3'd3, 3'd2, 3'd1};
    localparam logic [31:0] TD = 32'hA3A5A1A0;

    reg_write_arbiter #(.WIDTH(8), .ADDR_W(3), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
        .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input string sig, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s %s: got %0h required %0h", name, sig, got, exp);
        end
    endtask

    function automatic logic [3:0] model_gnt(input logic r, input logic [3:0] rq);
        int base;
        if (r) return 4'b0000;
        if (m_holder >= 0 && rq[m_holder] && m_cnt < MAXB) return 4'(1 << m_holder);
`ifdef REG_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = m_ptr;
`endif
        for (int k = 0; k < 4; k++) begin
            if (rq[(base + k) % 4]) return 4'(1 << ((base + k) % 4));
        end
        return 4'b0000;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                              input logic [11:0] ad, input logic [31:0] dt, input logic [3:0] g);
        int w;
        if (r) begin
            m_ptr = 0; m_holder = -1; m_cnt = 0;
            m_we = 0; m_addr = 0; m_data = 0;
            return;
        end
        if (g == 4'b0000) begin
            m_we = 0;
            if (m_holder >= 0 && !rq[m_holder]) begin
                m_holder = -1; m_cnt = 0;
            end
            return;
        end
        w = 0;
        for (int k = 0; k < 4; k++) if (g[k]) w = k;
        m_we   = 1;
        m_addr = ad[w*3 +: 3];
        m_data = dt[w*8 +: 8];
        m_ptr  = (w + 1) % 4;
        if (m_holder == w) begin
            if (lk[w] && m_cnt + 1 < MAXB) m_cnt = m_cnt + 1;
            else begin m_holder = -1; m_cnt = 0; end
        end else if (lk[w] && MAXB > 1) begin
            m_holder = w; m_cnt = 1;
        end else begin
            m_holder = -1; m_cnt = 0;
        end
    endtask

    task automatic run_cycle(input string name, input logic r, input logic [3:0] rq,
                             input logic [3:0] lk, input logic [11:0] ad, input logic [31:0] dt,
                             input logic use_tab, input vec_t v);
        logic [3:0] mg;
        rst = r; req = rq; lock = lk; req_addr = ad; req_data = dt;
        #2;
        mg = model_gnt(r, rq);
        check(name, "gnt", 32'(gnt), 32'(use_tab ? v.g : mg));
        @(posedge clk);
        #1;
        model_step(r, rq, lk, ad, dt, mg);
        if (use_tab) begin
            check(name, "wr_we",   32'(wr_we),   32'(v.we));
            check(name, "wr_addr", 32'(wr_addr), 32'(v.a));
            check(name, "wr_data", 32'(wr_data), 32'(v.d));
            check(name, "busy",    32'(busy),    32'(v.b));
        end else begin
            check(name, "wr_we",   32'(wr_we),   32'(m_we));
            check(name, "wr_addr", 32'(wr_addr), 32'(m_addr));
            check(name, "wr_data", 32'(wr_data), 32'(m_data));
            check(name, "busy",    32'(busy),    32'(m_holder >= 0));
        end
    endtask

    function automatic void add(input string n, input logic r, input logic [3:0] rq,
                                input logic [3:0] lk, input logic [3:0] g, input logic we,
                                input logic [2:0] a, input logic [7:0] d, input logic b);
        vec_t v;
        v.name = n; v.r = r; v.rq = rq; v.lk = lk; v.g = g;
        v.we = we; v.a = a; v.d = d; v.b = b;
        tab.push_back(v);
    endfunction

    initial begin
        vec_t dummy;
        rst = 1; req = 0; lock = 0; req_addr = 0; req_data = 0;
        dummy = '{name: "", r: 0, rq: 0, lk: 0, g: 0, we: 0, a: 0, d: 0, b: 0};
        repeat (2) @(posedge clk);
        #1;
        model_step(1'b1, 4'b0, 4'b0, 12'b0, 32'b0, 4'b0);

`ifdef REG_ARB_FIXED_PRIO_EN
        add("reset",      1, 4'b1111, 4'b0000, 4'b0000, 0, 3'd0, 8'h00, 0);
        add("fixed_1010", 0, 4'b1010, 4'b0000, 4'b0010, 1, 3'd2, 8'hA1, 0);
        add("fixed_1010", 0, 4'b1010, 4'b0000, 4'b0010, 1, 3'd2, 8'hA1, 0);
        add("fixed_1010", 0, 4'b1010, 4'b0000, 4'b0010, 1, 3'd2, 8'hA1, 0);
        add("fixed_1000", 0, 4'b1000, 4'b0000, 4'b1000, 1, 3'd4, 8'hA3, 0);
`else
        add("reset",      1, 4'b1111, 4'b0000, 4'b0000, 0, 3'd0, 8'h00, 0);
        add("single",     0, 4'b0100, 4'b0000, 4'b0100, 1, 3'd3, 8'hA5, 0);
        add("single_idle",0, 4'b0000, 4'b0000, 4'b0000, 0, 3'd3, 8'hA5, 0);
        add("reset2",     1, 4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 8'h00, 0);
        for (int n = 0; n < 2; n++) begin
            add("rr_0", 0, 4'b1111, 4'b0000, 4'b0001, 1, 3'd1, 8'hA0, 0);
            add("rr_1", 0, 4'b1111, 4'b0000, 4'b0010, 1, 3'd2, 8'hA1, 0);
            add("rr_2", 0, 4'b1111, 4'b0000, 4'b0100, 1, 3'd3, 8'hA5, 0);
            add("rr_3", 0, 4'b1111, 4'b0000, 4'b1000, 1, 3'd4, 8'hA3, 0);
        end
        add("set_ptr1",   0, 4'b0001, 4'b0000, 4'b0001, 1, 3'd1, 8'hA0, 0);
        add("burst_1",    0, 4'b0011, 4'b0010, 4'b0010, 1, 3'd2, 8'hA1, 1);
        add("burst_2",    0, 4'b0011, 4'b0010, 4'b0010, 1, 3'd2, 8'hA1, 1);
        add("burst_3",    0, 4'b0011, 4'b0010, 4'b0010, 1, 3'd2, 8'hA1, 1);
        add("burst_cap",  0, 4'b0011, 4'b0010, 4'b0010, 1, 3'd2, 8'hA1, 0);
        add("burst_after",0, 4'b0011, 4'b0000, 4'b0001, 1, 3'd1, 8'hA0, 0);
        add("early_1",    0, 4'b0011, 4'b0010, 4'b0010, 1, 3'd2, 8'hA1, 1);
        add("early_2",    0, 4'b0011, 4'b0010, 4'b0010, 1, 3'd2, 8'hA1, 1);
        add("early_drop", 0, 4'b0001, 4'b0010, 4'b0001, 1, 3'd1, 8'hA0, 0);
        add("mid_1",      0, 4'b0011, 4'b0010, 4'b0010, 1, 3'd2, 8'hA1, 1);
        add("mid_2",      0, 4'b0011, 4'b0010, 4'b0010, 1, 3'd2, 8'hA1, 1);
        add("mid_rst",    1, 4'b0011, 4'b0010, 4'b0000, 0, 3'd0, 8'h00, 0);
        add("post_rst_0", 0, 4'b0011, 4'b0000, 4'b0001, 1, 3'd1, 8'hA0, 0);
        add("post_rst_1", 0, 4'b0011, 4'b0000, 4'b0010, 1, 3'd2, 8'hA1, 0);
        add("lock_noreq", 0, 4'b0100, 4'b1000, 4'b0100, 1, 3'd3, 8'hA5, 0);
`endif

        foreach (tab[i]) begin
            run_cycle(tab[i].name, tab[i].r, tab[i].rq, tab[i].lk, TA, TD, 1'b1, tab[i]);
        end

        for (int n = 0; n < 600; n++) begin
            logic        r;
            logic [3:0]  rq, lk;
            r  = ($urandom_range(0, 49) == 0);
            rq = 4'($urandom);
            lk = ($urandom_range(0, 3) != 0) ? 4'($urandom) : 4'b0000;
            run_cycle("rand", r, rq, lk, 12'($urandom), $urandom, 1'b0, dummy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
